// File: rtl/turbo_itl_pp.sv
// turbo_itl_pp -- ping-pong buffered HPGP turbo interleaver / deinterleaver.
//
// A PHY block arrives in natural order and leaves permuted by
// pi(k) = (k*STEP) mod L, or by the inverse permutation in deinterleave mode.
// Two banks let one block be written while the previous one is read out.
//
// Ports:
//   clk, n_rst            clock (rising edge), async active-low reset
//   pb_size[1:0]          0:L=64  1:L=544  2:L=2080  3:treated as 2 + err
//   mode                  0 interleave, 1 deinterleave
//   din/din_vld/din_sop   input symbol stream, din_sop marks symbol 0
//   din_rdy               a write bank is free
//   dout/dout_vld         registered output stream, no backpressure
//   dout_sop/dout_eop     first / last output symbol of a block
//   err                   one-cycle pulse on a protocol error
//
// Build option: define TURBO_ITL_DITL_EN to honour the mode input (per-bank
// mode latch plus a write-side permutation generator). Without it the block
// is interleave-only and mode is ignored.
module turbo_itl_pp #(
    parameter int DATA_W = 2,
    parameter int ADDR_W = 12,
    parameter int STEP0  = 13,
    parameter int STEP1  = 31,
    parameter int STEP2  = 67
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [1:0]        pb_size,
    input  logic              mode,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    input  logic              din_sop,
    output logic              din_rdy,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    output logic              dout_sop,
    output logic              dout_eop,
    output logic              err
);
    localparam int DEPTH = 1 << ADDR_W;
    typedef logic [ADDR_W:0]   wide_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef enum logic { R_IDLE, R_RUN } rstate_e;

    function automatic wide_t len_of(input logic [1:0] sz);
        case (sz)
            2'd0:    len_of = wide_t'(64);
            2'd1:    len_of = wide_t'(544);
            default: len_of = wide_t'(2080);
        endcase
    endfunction

    function automatic wide_t step_of(input logic [1:0] sz);
        case (sz)
            2'd0:    step_of = wide_t'(STEP0);
            2'd1:    step_of = wide_t'(STEP1);
            default: step_of = wide_t'(STEP2);
        endcase
    endfunction

    // Incremental pi: add STEP, fold once (STEP < L so one subtract suffices).
    function automatic addr_t perm_next(input addr_t p, input logic [1:0] sz);
        wide_t s;
        s = {1'b0, p} + step_of(sz);
        if (s >= len_of(sz)) s = s - len_of(sz);
        perm_next = s[ADDR_W-1:0];
    endfunction

    logic [DATA_W-1:0] mem0 [DEPTH];
    logic [DATA_W-1:0] mem1 [DEPTH];

    logic [1:0]  full_q, full_d;
    logic        wb_q, open_q, err_q, err_d;
    addr_t       wcnt_q, wcnt_cur, waddr;
    logic [1:0]  len_q [2];
    logic [1:0]  sz_in, wsz, rsz;
    logic        acc, we, wlast, rmode;

    rstate_e     state_q, state_d;
    logic        rb_q, issue, rd_last;
    addr_t       rcnt_q, rp_q, raddr;
    logic [DATA_W-1:0] rdata_q, dout_q;
    logic        rd_vld_q, rd_sop_q, rd_eop_q;
    logic        dout_vld_q, dout_sop_q, dout_eop_q;

    // ---------------- write side ----------------
    always_comb begin
        acc      = din_vld & din_rdy;
        sz_in    = (pb_size == 2'd3) ? 2'd2 : pb_size;
        // On a sop the block parameters come straight from the inputs.
        wsz      = din_sop ? sz_in : len_q[wb_q];
        wcnt_cur = din_sop ? '0 : wcnt_q;
        we       = acc & (din_sop | open_q);
        wlast    = ({1'b0, wcnt_cur} == len_of(wsz) - wide_t'(1));
        err_d    = acc & (din_sop ? (pb_size == 2'd3 || open_q) : !open_q);
    end

`ifdef TURBO_ITL_DITL_EN
    logic  mode_q [2];
    logic  wmode;
    addr_t wp_q, wperm;

    always_comb begin
        wmode = din_sop ? mode : mode_q[wb_q];
        wperm = din_sop ? '0 : wp_q;
        waddr = wmode ? wperm : wcnt_cur;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mode_q[0] <= 1'b0;
            mode_q[1] <= 1'b0;
            wp_q      <= '0;
        end else if (we) begin
            if (din_sop) mode_q[wb_q] <= mode;
            wp_q <= wlast ? '0 : perm_next(wperm, wsz);
        end
    end

    assign rmode = mode_q[rb_q];
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign waddr       = wcnt_cur;
    assign rmode       = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wb_q     <= 1'b0;
            open_q   <= 1'b0;
            wcnt_q   <= '0;
            len_q[0] <= 2'd0;
            len_q[1] <= 2'd0;
            err_q    <= 1'b0;
        end else begin
            err_q <= err_d;
            if (acc & din_sop) len_q[wb_q] <= sz_in;
            if (we) begin
                open_q <= !wlast;
                wcnt_q <= wlast ? '0 : wcnt_cur + addr_t'(1);
                if (wlast) wb_q <= ~wb_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we && !wb_q) mem0[waddr] <= din;
        if (we &&  wb_q) mem1[waddr] <= din;
    end

    assign din_rdy = !full_q[wb_q];

    // ---------------- read side ----------------
    // The first issue happens in the same cycle the FSM leaves R_IDLE, which
    // keeps last-accept -> first dout_vld at two edges.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        rsz     = len_q[rb_q];
        raddr   = rmode ? rcnt_q : rp_q;
        case (state_q)
            R_IDLE: if (full_q[rb_q]) begin
                issue   = 1'b1;
                state_d = R_RUN;
            end
            R_RUN:  issue = 1'b1;
        endcase
        rd_last = issue & ({1'b0, rcnt_q} == len_of(rsz) - wide_t'(1));
        if (rd_last) state_d = full_q[~rb_q] ? R_RUN : R_IDLE;
        // Reader release and writer completion always hit different banks.
        full_d = full_q;
        if (rd_last)     full_d[rb_q] = 1'b0;
        if (we & wlast)  full_d[wb_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (issue) rdata_q <= rb_q ? mem1[raddr] : mem0[raddr];
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= R_IDLE;
            full_q     <= '0;
            rb_q       <= 1'b0;
            rcnt_q     <= '0;
            rp_q       <= '0;
            rd_vld_q   <= 1'b0;
            rd_sop_q   <= 1'b0;
            rd_eop_q   <= 1'b0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            dout_sop_q <= 1'b0;
            dout_eop_q <= 1'b0;
        end else begin
            state_q <= state_d;
            full_q  <= full_d;
            if (issue) begin
                if (rd_last) begin
                    rcnt_q <= '0;
                    rp_q   <= '0;
                    rb_q   <= ~rb_q;
                end else begin
                    rcnt_q <= rcnt_q + addr_t'(1);
                    rp_q   <= perm_next(rp_q, rsz);
                end
            end
            rd_vld_q   <= issue;
            rd_sop_q   <= issue & (rcnt_q == '0);
            rd_eop_q   <= rd_last;
            dout_q     <= rd_vld_q ? rdata_q : '0;
            dout_vld_q <= rd_vld_q;
            dout_sop_q <= rd_sop_q;
            dout_eop_q <= rd_eop_q;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign dout_sop = dout_sop_q;
    assign dout_eop = dout_eop_q;
    assign err      = err_q;
endmodule

// File: tb/tb_turbo_itl_pp.sv
// Randomised bench for turbo_itl_pp. A block-level reference model predicts,
// for every clock edge, the output symbol and flags, din_rdy and err pulses;
// one compare process checks the DUT against it on every cycle.
module tb_turbo_itl_pp;
    localparam int DW = 8;
    typedef logic [DW-1:0] q8_t[$];

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic [1:0]    pb_size = 2'd0;
    logic          mode = 1'b0;
    logic [DW-1:0] din = '0;
    logic          din_vld = 1'b0, din_sop = 1'b0;
    logic          din_rdy, dout_vld, dout_sop, dout_eop, err;
    logic [DW-1:0] dout;

    turbo_itl_pp #(.DATA_W(DW)) dut (
        .clk(clk), .n_rst(n_rst), .pb_size(pb_size), .mode(mode),
        .din(din), .din_vld(din_vld), .din_sop(din_sop), .din_rdy(din_rdy),
        .dout(dout), .dout_vld(dout_vld), .dout_sop(dout_sop),
        .dout_eop(dout_eop), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    longint  ecnt = 0;               // number of the most recent rising edge
    bit      mopen, mmode, mwb;
    int      mL, mstep;
    q8_t     blk;
    longint  rel_e[2];               // edge at which each bank is handed back
    longint  next_free;
    longint  last_acc_edge, first_vld_edge, sop_edge, eop_edge;
    int      err_seen = 0;
    logic [DW-1:0] exp_d[longint];
    bit      exp_s[longint], exp_e[longint], exp_err[longint];

    function automatic int len_of(input int sz);
        return (sz == 0) ? 64 : (sz == 1) ? 544 : 2080;
    endfunction
    function automatic int step_of(input int sz);
        return (sz == 0) ? 13 : (sz == 1) ? 31 : 67;
    endfunction

    // Block finished at edge c: lay out its outputs on absolute edge numbers.
    task automatic complete(input longint c);
        longint st;
        int     idx;
        st = (c + 2 > next_free) ? c + 2 : next_free;
        for (int k = 0; k < mL; k++) begin
            idx = (k * mstep) % mL;
            if (!mmode) exp_d[st + k] = blk[idx];
            else        exp_d[st + idx] = blk[k];
            exp_s[st + k] = (k == 0);
            exp_e[st + k] = (k == mL - 1);
        end
        next_free  = st + mL;
        rel_e[mwb] = st + mL - 2;     // last read issue edge
        mwb        = !mwb;
        mopen      = 0;
    endtask

    always @(posedge clk) begin
        int sz;
        ecnt++;
        if (!n_rst) begin
            mopen = 0; mwb = 0; rel_e[0] = 0; rel_e[1] = 0; next_free = 0;
            blk.delete(); exp_d.delete(); exp_s.delete(); exp_e.delete();
            exp_err.delete();
        end else if (din_vld && !((ecnt - 1) < rel_e[mwb])) begin
            last_acc_edge = ecnt;
            if (din_sop) begin
                if (pb_size == 2'd3 || mopen) exp_err[ecnt] = 1;
                sz    = (pb_size == 2'd3) ? 2 : int'(pb_size);
                mL    = len_of(sz);
                mstep = step_of(sz);
`ifdef TURBO_ITL_DITL_EN
                mmode = mode;
`else
                mmode = 0;
`endif
                blk.delete();
                blk.push_back(din);
                mopen = 1;
            end else if (!mopen) begin
                exp_err[ecnt] = 1;
            end else begin
                blk.push_back(din);
            end
            if (mopen && blk.size() == mL) complete(ecnt);
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (n_rst) begin
            chk("din_rdy", din_rdy, !(ecnt < rel_e[mwb]));
            chk("err", err, exp_err.exists(ecnt));
            if (exp_d.exists(ecnt)) begin
                chk("dout_vld", dout_vld, 1);
                chk("dout", dout, exp_d[ecnt]);
                chk("dout_sop", dout_sop, exp_s[ecnt]);
                chk("dout_eop", dout_eop, exp_e[ecnt]);
                exp_d.delete(ecnt); exp_s.delete(ecnt); exp_e.delete(ecnt);
            end else begin
                chk("dout_vld_idle", dout_vld, 0);
                chk("dout_sop_idle", dout_sop, 0);
                chk("dout_eop_idle", dout_eop, 0);
            end
            if (exp_err.exists(ecnt)) exp_err.delete(ecnt);
            if (err) err_seen++;
            if (dout_vld && first_vld_edge < 0) first_vld_edge = ecnt;
            if (dout_sop) sop_edge = ecnt;
            if (dout_eop) eop_edge = ecnt;
        end
    end

    // ---------------- stimulus ----------------
    function automatic q8_t rnd(input int n);
        q8_t q;
        for (int i = 0; i < n; i++) q.push_back(DW'($urandom_range(0, 255)));
        return q;
    endfunction

    function automatic longint expv(input longint key);
        return exp_d.exists(key) ? longint'(exp_d[key]) : -1;
    endfunction

    task automatic send(input logic [DW-1:0] d, input bit sop,
                        input logic [1:0] sz, input bit md);
        int g = 0;
        din = d; din_sop = sop; pb_size = sz; mode = md; din_vld = 1'b1;
        while (!din_rdy && g < 10000) begin @(negedge clk); g++; end
        if (!din_rdy) chk("din_rdy_timeout", 0, 1);
        @(negedge clk);
        din_vld = 1'b0; din_sop = 1'b0;
    endtask

    task automatic send_blk(input q8_t q, input logic [1:0] sz, input bit md,
                            input int gap_pct);
        for (int k = 0; k < q.size(); k++) begin
            if (k > 0 && gap_pct > 0 && $urandom_range(0, 99) < gap_pct)
                @(negedge clk);
            send(q[k], k == 0, sz, md);
        end
    endtask

    task automatic drain();
        int g = 0;
        while (exp_d.size() != 0 && g < 20000) begin @(negedge clk); g++; end
        if (exp_d.size() != 0) chk("drain_timeout", exp_d.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        q8_t    q;
        longint st;
        int     eb;
        first_vld_edge = -1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_dout", dout, 0);
        chk("rst_vld", dout_vld, 0);
        chk("rst_sop", dout_sop, 0);
        chk("rst_eop", dout_eop, 0);
        chk("rst_err", err, 0);
        chk("rst_rdy", din_rdy, 1);
        @(negedge clk); #2 n_rst = 1'b1;
        @(negedge clk);

        // PB16 interleave of 0..63
        q.delete();
        for (int k = 0; k < 64; k++) q.push_back(DW'(k));
        first_vld_edge = -1;
        send_blk(q, 2'd0, 1'b0, 0);
        st = last_acc_edge + 2;
        chk("model_k0", expv(st), 0);
        chk("model_k1", expv(st + 1), 13);
        chk("model_k5", expv(st + 5), 1);
        chk("model_k63", expv(st + 63), 51);
        drain();
        chk("latency", first_vld_edge - last_acc_edge, 2);
        chk("sop_to_eop", eop_edge - sop_edge, 63);

        // PB16 interleaved sequence fed back with mode=1
        q.delete();
        for (int j = 0; j < 64; j++) q.push_back(DW'((13 * j) % 64));
        send_blk(q, 2'd0, 1'b1, 0);
        st = last_acc_edge + 2;
`ifdef TURBO_ITL_DITL_EN
        chk("model_deitl_k5", expv(st + 5), 5);
`else
        chk("model_itl_only_k5", expv(st + 5), 13);
`endif
        drain();

        // 3x PB520 back to back
        for (int b = 0; b < 3; b++) send_blk(rnd(2080), 2'd2, 1'($urandom_range(0, 1)), 0);
        drain();

        // PB136 then PB16
        send_blk(rnd(544), 2'd1, 1'b0, 0);
        send_blk(rnd(64), 2'd0, 1'($urandom_range(0, 1)), 0);
        drain();

        // protocol errors: size 3, restart at wcnt=10, data with no open block
        eb = err_seen;
        send_blk(rnd(2080), 2'd3, 1'b0, 0);
        q = rnd(10);
        send_blk(q, 2'd0, 1'b0, 0);
        send_blk(rnd(64), 2'd0, 1'b0, 0);
        drain();
        for (int i = 0; i < 3; i++) send(DW'(i + 7), 1'b0, 2'd0, 1'b0);
        drain();
        chk("err_pulses", err_seen - eb, 5);

        // reset in the middle of a read-out
        send_blk(rnd(544), 2'd1, 1'($urandom_range(0, 1)), 0);
        repeat (20) @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        chk("mid_rst_dout", dout, 0);
        chk("mid_rst_vld", dout_vld, 0);
        chk("mid_rst_eop", dout_eop, 0);
        chk("mid_rst_rdy", din_rdy, 1);
        @(negedge clk); @(negedge clk);
        #2 n_rst = 1'b1;
        @(negedge clk);
        send_blk(rnd(64), 2'd0, 1'b0, 0);
        drain();

        // random mix with gaps inside and between blocks
        for (int b = 0; b < 8; b++) begin
            send_blk(rnd(len_of(b % 2 == 0 ? 0 : int'($urandom_range(0, 1)))),
                     2'(b % 2 == 0 ? 0 : 0), 1'($urandom_range(0, 1)), 10);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        for (int b = 0; b < 4; b++) begin
            eb = $urandom_range(0, 1);
            send_blk(rnd(len_of(eb)), 2'(eb), 1'($urandom_range(0, 1)), 10);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/turbo_itl_pp.md
# turbo_itl_pp

Parametrised, ping-pong-buffered HPGP turbo interleaver/deinterleaver. It accepts symbols for one PHY block (PB) in natural order and emits the same block permuted by π(k) = (k·STEP) mod L, or performs the inverse. Two memory banks let one PB be written while the previous PB is read out. The block sits between the turbo encoder/bit source and the mapper, replacing the fixed single-buffer interleaver top.

## Interface
- DATA_W, 2, bits per symbol (one memory word)
- ADDR_W, 12, bank address width; 2^ADDR_W must be ≥ 2080
- STEP0, 13, permutation step for L=64 (PB16)
- STEP1, 31, permutation step for L=544 (PB136)
- STEP2, 67, permutation step for L=2080 (PB520)
- Each STEPn is coprime with its L and smaller than L.

Ports:
- clk  in  1  clock, all logic on the rising edge
- n_rst  in  1  reset, asynchronous, active-low
- pb_size  in  2  0→L=64, 1→L=544, 2→L=2080, 3 reserved
- mode  in  1  0 interleave, 1 deinterleave
- din  in  DATA_W  input symbol
- din_vld  in  1  din valid
- din_sop  in  1  first symbol of a PB, qualified by din_vld
- din_rdy  out  1  a write bank is available
- dout  out  DATA_W  output symbol, registered
- dout_vld  out  1  dout valid
- dout_sop  out  1  first output symbol of a PB
- dout_eop  out  1  last output symbol of a PB
- err  out  1  one-cycle pulse on a protocol error

## Operation
- Accept: a symbol is accepted on a cycle where din_vld & din_rdy are both high.
- Storage: two banks, bank[0] and bank[1], each 2^ADDR_W × DATA_W, with a synchronous read port.
- Each bank has a flag full[b]. The write pointer wb and read pointer rb reset to 0.
- Write side:
  - On an accepted din_sop, latch pb_size and mode into the per-bank registers len[wb]/mode[wb], clear wcnt, and start the permutation generator.
  - pb_size 3 is treated as 2 and pulses err.
  - The write address is wcnt (interleave) or π(wcnt) (deinterleave).
  - On the accept with wcnt = L−1: set full[wb] and toggle wb.
  - An accept without din_sop while no block is open is dropped and pulses err.
  - An accept with din_sop while a block is open discards the partial block, restarts at wcnt=0 and pulses err.
- din_rdy = !full[wb].
- Read side FSM:
  - R_IDLE → R_RUN when full[rb].
  - In R_RUN, issue one read per cycle. The read address is π(rcnt) (interleave) or rcnt (deinterleave), using len/mode latched for bank rb.
  - After issuing rcnt = L−1: clear full[rb] and toggle rb. Go to R_RUN again if the other bank is full, else R_IDLE. There are zero idle cycles between back-to-back PBs.
- Permutation generator: incremental, p0 = 0, p(k+1) = p + STEP − (p + STEP ≥ L ? L : 0). It has ADDR_W+1 bit intermediate width, uses no multiplier, and there is one instance per side.
- Write and read never target the same bank. The read side clears full on the same edge as its last issue, so the writer may take that bank on the following cycle.

## Timing
- Reset values: din_rdy=1, dout=0, dout_vld=0, dout_sop=0, dout_eop=0, err=0. Both full flags, wb, rb, counters and FSM (R_IDLE) are cleared.
- Latency: if the read side is idle, the first dout_vld is asserted 2 cycles after the edge that accepts the last symbol. That is one cycle for the address issue and one for the RAM/output register.
- Throughput: 1 symbol/cycle sustained on both sides. Input stalls only when both banks are full.
- dout_sop/dout_eop coincide with dout_vld on the first and last symbol. For L=64, dout_eop is 63 cycles after dout_sop.
- The output has no backpressure; the downstream must accept one symbol per cycle.
- Reset asserted mid-block aborts everything immediately, with no partial output.
- A simultaneous last-write to bank A and last-read from bank B is legal and releases B to the writer on the next cycle.

## Configuration
- TURBO_ITL_DITL_EN defined: the mode input is honoured, with per-bank mode latching, as above.
- Undefined: the mode input is ignored and the block is interleave-only. The write address is always wcnt and only the read-side permutation generator is built.

## Test plan
- PB16 interleave, DATA_W=8, din = k for k=0..63 with din_sop at k=0 → dout = 0,13,26,39,52,1,14,… with dout_sop on 0 and dout_eop on the 64th symbol, first dout_vld 2 cycles after the last accept.
- Interleave then deinterleave: feed the PB16 interleaved sequence with mode=1 → dout = 0,1,2,…,63.
- Back-to-back PB520 ×3 continuous → din_rdy drops only while both banks are full, the output is gap-free for 3×2080 cycles, and each block is permuted with STEP2.
- Mixed sizes PB136 then PB16 → each bank uses its own latched L (544 then 64), and the eops land at the correct counts.
- Errors: pb_size=3 pulses err once and the block behaves as L=2080. A din_sop at wcnt=10 pulses err, restarts the block and produces exactly L outputs. Data without an open block pulses err and is dropped.
- n_rst pulsed low mid-read → all outputs 0 immediately, din_rdy=1, and the next PB is processed correctly.
